alu_issue_ctrl: RTL and testbench

- Issue/retire controller that drives the calculator's combinational 32-bit ALU (A, B, 2-bit Func; outputs out, C, Z, N, V).
- Accepts one operation at a time over a valid/ready handshake and evaluates its 4-bit ARM condition field against a stored NZCV register.
- Drives the ALU, registers the result, and optionally updates NZCV (S bit).
- Presents the result to the display/writeback stage over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller for the calculator's combinational ALU: accepts one
// operation, evaluates its ARM condition against stored NZCV, and hands back the result.
module alu_issue_ctrl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_cond,
    input  logic [1:0]    in_func,
    input  logic          in_s,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [1:0]    alu_func,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_c,
    input  logic          alu_z,
    input  logic          alu_n,
    input  logic          alu_v,
    input  logic          flag_clr,
    output logic [3:0]    flags,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_skipped
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cond;
    logic [1:0]    r_func;
    logic          r_s;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_res_data;
    logic          r_res_skipped;
    logic [3:0]    r_flags;
    logic          w_pass;

    // ARM condition table; f is {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return c;
            4'b0011: return !c;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return c && !z;
            4'b1001: return !c || z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z && (n == v);
            4'b1101: return z || (n != v);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign w_pass = cond_pass(r_cond, r_flags);

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_DONE;
            S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cond        <= 4'b0000;
            r_func        <= 2'b00;
            r_s           <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_res_data    <= '0;
            r_res_skipped <= 1'b0;
            r_flags       <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && in_valid) begin
                r_cond <= in_cond;
                r_func <= in_func;
                r_s    <= in_s;
                r_a    <= in_a;
                r_b    <= in_b;
            end
            if (r_state == S_EXEC) begin
                r_res_data    <= w_pass ? alu_out : '0;
                r_res_skipped <= !w_pass;
            end
            // Clear wins over an S update landing on the same edge.
            if (flag_clr)
                r_flags <= 4'b0000;
            else if (r_state == S_EXEC && w_pass && r_s)
                r_flags <= {alu_n, alu_z, alu_c, alu_v};
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign res_valid   = (r_state == S_DONE);
    assign res_data    = r_res_data;
    assign res_skipped = r_res_skipped;
    assign flags       = r_flags;
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_func    = r_func;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios followed by random
// operations, compared against a flag/condition reference model kept here.
module tb_alu_issue_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_cond;
    logic [1:0]    in_func;
    logic          in_s;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_func;
    logic [DW-1:0] alu_out;
    logic          alu_c;
    logic          alu_z;
    logic          alu_n;
    logic          alu_v;
    logic          flag_clr;
    logic [3:0]    flags;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          res_skipped;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [3:0]    m_flags;

    alu_issue_ctrl #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cond(in_cond), .in_func(in_func), .in_s(in_s),
        .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
        .flag_clr(flag_clr), .flags(flags),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_skipped(res_skipped)
    );

    always #5 clk = ~clk;

    // Reference ALU arithmetic: returns {N,Z,C,V, out}; C on subtract means "no borrow".
    function automatic logic [35:0] alu_ref(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned u;
        longint          sg;
        logic [31:0]     o;
        logic            c;
        logic            v;
        c = 1'b0;
        v = 1'b0;
        case (f)
            2'd0: begin
                u  = longint'(a) + longint'(b);
                sg = longint'($signed(a)) + longint'($signed(b));
                o  = u[31:0];
                c  = (u > 64'hFFFF_FFFF);
                v  = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
            end
            2'd1: begin
                sg = longint'($signed(a)) - longint'($signed(b));
                o  = a - b;
                c  = (a >= b);
                v  = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
            end
            2'd2:    o = a & b;
            default: o = a | b;
        endcase
        return {o[31], (o == 32'd0), c, v, o};
    endfunction

    // Combinational ALU the controller drives.
    always_comb begin
        logic [35:0] r;
        r = alu_ref(alu_func, alu_a, alu_b);
        {alu_n, alu_z, alu_c, alu_v, alu_out} = r;
    end

    // ARM rule: cond[3:1] selects a base test, cond[0] inverts it (AL/NV pair included).
    function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, b;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0: b = z;
            3'd1: b = c;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = c & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return cond[0] ? ~b : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        in_cond = 4'($urandom);
        in_func = 2'($urandom);
        in_s    = 1'($urandom);
        in_a    = $urandom;
        in_b    = $urandom;
    endtask

    // One full operation; called at posedge+1 with the DUT idle.
    task automatic do_op(input logic [3:0] cond, input logic [1:0] func, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input int delay,
                         input bit clr_exec, input bit rst_done);
        logic [35:0] r;
        logic        pass;
        logic [31:0] exp_data;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_cond   = cond;
        in_func   = func;
        in_s      = s;
        in_a      = a;
        in_b      = b;
        res_ready = (delay == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        check("exec_in_ready", 32'(in_ready), 32'd0);
        check("exec_res_valid", 32'(res_valid), 32'd0);
        check("exec_alu_a", alu_a, a);
        check("exec_alu_b", alu_b, b);
        check("exec_alu_func", 32'(alu_func), 32'(func));
        flag_clr = clr_exec;
        r        = alu_ref(func, a, b);
        pass     = ref_pass(cond, m_flags);
        exp_data = pass ? r[31:0] : 32'd0;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        if (clr_exec)
            m_flags = 4'b0000;
        else if (pass && s)
            m_flags = r[35:32];
        check("done_res_valid", 32'(res_valid), 32'd1);
        check("done_res_data", res_data, exp_data);
        check("done_res_skipped", 32'(res_skipped), 32'(!pass));
        check("done_flags", 32'(flags), 32'(m_flags));
        check("done_in_ready", 32'(in_ready), 32'd0);
        if (rst_done) begin
            #2 rst = 1'b1;
            #1;
            m_flags = 4'b0000;
            check("arst_res_valid", 32'(res_valid), 32'd0);
            check("arst_flags", 32'(flags), 32'd0);
            check("arst_in_ready", 32'(in_ready), 32'd1);
            check("arst_res_data", res_data, 32'd0);
            #1 rst = 1'b0;
            res_ready = 1'b0;
            @(posedge clk); #1;
        end else begin
            // An offered request during DONE must not be taken.
            in_valid = 1'b1;
            for (int i = 0; i < delay; i++) begin
                @(posedge clk); #1;
                check("hold_res_valid", 32'(res_valid), 32'd1);
                check("hold_res_data", res_data, exp_data);
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            in_valid  = 1'b0;
            check("rel_res_valid", 32'(res_valid), 32'd0);
            check("rel_in_ready", 32'(in_ready), 32'd1);
            check("rel_flags", 32'(flags), 32'(m_flags));
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        case ($urandom_range(0, 2))
            0:       return 32'($urandom_range(0, 15));
            1:       return corners[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        flag_clr  = 1'b0;
        in_cond   = 4'd0;
        in_func   = 2'd0;
        in_s      = 1'b0;
        in_a      = '0;
        in_b      = '0;
        m_flags   = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_skipped", 32'(res_skipped), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_func", 32'(alu_func), 32'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        do_op(4'b1110, 2'b00, 1'b1, 32'd5, 32'd7, 0, 1'b0, 1'b0);
        do_op(4'b1110, 2'b01, 1'b1, 32'd9, 32'd9, 1, 1'b0, 1'b0);
        do_op(4'b0000, 2'b11, 1'b0, 32'h0F, 32'hF0, 0, 1'b0, 1'b0);
        do_op(4'b1110, 2'b00, 1'b1, 32'd1, 32'd2, 0, 1'b0, 1'b0);
        do_op(4'b0000, 2'b00, 1'b0, 32'd3, 32'd4, 2, 1'b0, 1'b0);
        do_op(4'b1110, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0000_FFFF, 5, 1'b0, 1'b0);
        do_op(4'b1110, 2'b01, 1'b1, 32'd1, 32'd2, 1, 1'b1, 1'b0);

        // Clear while idle, after an op that leaves N set.
        do_op(4'b1110, 2'b01, 1'b1, 32'd1, 32'd2, 0, 1'b0, 1'b0);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        m_flags  = 4'b0000;
        check("idle_clr_flags", 32'(flags), 32'd0);

        do_op(4'b1110, 2'b01, 1'b1, 32'd1, 32'd2, 3, 1'b0, 1'b1);
        do_op(4'b1111, 2'b00, 1'b1, 32'd4, 32'd4, 0, 1'b0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            ra = rnd_operand();
            rb = ($urandom_range(0, 4) == 0) ? ra : rnd_operand();
            do_op(4'($urandom), 2'($urandom), 1'($urandom), ra, rb,
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
